// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART top level and its line buffer.
//   buf_mode_e     : operating mode of the line buffer (ECHO / LINE)
//   UART_TERM_CR   : carriage return, default line terminator
//   UART_PRESCALE  : baud prescale shared by uart_rx / uart_tx at top level
// -----------------------------------------------------------------------------
package uart_pkg;

    typedef enum logic [0:0] {
        MODE_ECHO = 1'b0,
        MODE_LINE = 1'b1
    } buf_mode_e;

    localparam logic [7:0]  UART_TERM_CR  = 8'h0D;
    localparam logic [15:0] UART_PRESCALE = 16'd35;

endpackage : uart_pkg

// File: rtl/line_fifo_mem.sv
// -----------------------------------------------------------------------------
// line_fifo_mem
// Storage array for the line buffer: one synchronous write port and one
// asynchronous (combinational) read port. Contents are not reset.
// Ports:
//   clk      : clock
//   wr_en    : write strobe
//   wr_addr  : write address
//   wr_data  : write data
//   rd_addr  : read address
//   rd_data  : read data, combinational from rd_addr
// -----------------------------------------------------------------------------
module line_fifo_mem #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16,
    parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);

    logic [DATA_WIDTH-1:0] mem_r [DEPTH];

    // Write port: store one entry per enabled clock edge.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_r[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem_r[rd_addr];

endmodule : line_fifo_mem

// File: rtl/uart_line_buffer.sv
// -----------------------------------------------------------------------------
// uart_line_buffer
// AXI-stream buffer between uart_rx and uart_tx.
//   ECHO mode: plain FIFO, back-pressures the receiver when full.
//   LINE mode: bytes are held until TERM is written, then the whole line is
//              released. Input is always accepted; bytes arriving while full
//              are dropped and counted. A full buffer with nothing committed
//              releases its partial line so the link cannot deadlock.
// Ports:
//   clk, rst                 : clock, asynchronous active-low reset
//   s_axis_tdata/tvalid/tready : input stream from uart_rx
//   m_axis_tdata/tvalid/tready : output stream to uart_tx
//   line_mode_i              : requested mode (0 = ECHO, 1 = LINE)
//   mode_o                   : mode in effect
//   level_o                  : entries stored
//   drop_count_o             : bytes dropped in LINE mode, saturating at 255
// -----------------------------------------------------------------------------
module uart_line_buffer
    import uart_pkg::*;
#(
    parameter int         DATA_WIDTH = 8,
    parameter int         DEPTH      = 16,
    parameter logic [7:0] TERM       = UART_TERM_CR
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [DATA_WIDTH-1:0]     s_axis_tdata,
    input  logic                      s_axis_tvalid,
    output logic                      s_axis_tready,
    output logic [DATA_WIDTH-1:0]     m_axis_tdata,
    output logic                      m_axis_tvalid,
    input  logic                      m_axis_tready,
    input  logic                      line_mode_i,
    output logic                      mode_o,
    output logic [$clog2(DEPTH):0]    level_o,
    output logic [7:0]                drop_count_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    localparam logic [0:0] ST_ECHO = 1'(MODE_ECHO);
    localparam logic [0:0] ST_LINE = 1'(MODE_LINE);

    localparam logic [DATA_WIDTH-1:0] TERM_W = DATA_WIDTH'(TERM);

    // Registered state
    logic [PW-1:0] wr_ptr_r;
    logic [PW-1:0] rd_ptr_r;
    logic [PW-1:0] cm_ptr_r;
    logic [0:0]    mode_r;
    logic [7:0]    drop_cnt_r;

    // Combinational control
    logic          full_s;
    logic          empty_s;
    logic          s_ready_s;
    logic          push_hs_s;
    logic          wr_en_s;
    logic          drop_s;
    logic          m_valid_s;
    logic          pop_s;
    logic          term_hit_s;
    logic [PW-1:0] wr_ptr_nxt_s;
    logic [PW-1:0] rd_ptr_nxt_s;
    logic [PW-1:0] cm_ptr_nxt_s;
    logic [0:0]    mode_nxt_s;
    logic [7:0]    drop_cnt_nxt_s;

    // Status flags and handshakes, all derived from registered pointers/state.
    always_comb begin
        full_s     = (wr_ptr_r[AW] != rd_ptr_r[AW]) &&
                     (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
        empty_s    = (wr_ptr_r == rd_ptr_r);
        if (mode_r == ST_LINE) begin
            s_ready_s = 1'b1;
        end else begin
            s_ready_s = !full_s;
        end
        push_hs_s  = s_axis_tvalid && s_ready_s;
        // Only LINE mode can see a handshake while full; that byte is discarded.
        wr_en_s    = push_hs_s && !full_s;
        drop_s     = push_hs_s && full_s && (mode_r == ST_LINE);
        m_valid_s  = (rd_ptr_r != cm_ptr_r);
        pop_s      = m_valid_s && m_axis_tready;
        term_hit_s = (s_axis_tdata == TERM_W);
    end

    // Next pointer values.
    always_comb begin
        wr_ptr_nxt_s = wr_ptr_r + {{AW{1'b0}}, wr_en_s};
        rd_ptr_nxt_s = rd_ptr_r + {{AW{1'b0}}, pop_s};
        cm_ptr_nxt_s = cm_ptr_r;
        case (mode_r)
            ST_ECHO: begin
                // Every stored byte is immediately visible to the reader.
                cm_ptr_nxt_s = wr_ptr_nxt_s;
            end
            ST_LINE: begin
                if (wr_en_s && term_hit_s) begin
                    // Commit up to and including the terminator.
                    cm_ptr_nxt_s = wr_ptr_nxt_s;
                end else if (full_s && (cm_ptr_r == rd_ptr_r)) begin
                    // Full with nothing committed: release the partial line.
                    cm_ptr_nxt_s = wr_ptr_r;
                end else begin
                    cm_ptr_nxt_s = cm_ptr_r;
                end
            end
            default: begin
                cm_ptr_nxt_s = wr_ptr_nxt_s;
            end
        endcase
    end

    // Mode FSM: switch only when drained; the request is re-sampled every cycle.
    always_comb begin
        if (empty_s && (line_mode_i != mode_r[0])) begin
            mode_nxt_s = line_mode_i;
        end else begin
            mode_nxt_s = mode_r;
        end
    end

    // Saturating drop counter.
    always_comb begin
        if (drop_s && (drop_cnt_r != 8'hFF)) begin
            drop_cnt_nxt_s = drop_cnt_r + 8'd1;
        end else begin
            drop_cnt_nxt_s = drop_cnt_r;
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_r   <= {PW{1'b0}};
            rd_ptr_r   <= {PW{1'b0}};
            cm_ptr_r   <= {PW{1'b0}};
            mode_r     <= ST_ECHO;
            drop_cnt_r <= 8'd0;
        end else begin
            wr_ptr_r   <= wr_ptr_nxt_s;
            rd_ptr_r   <= rd_ptr_nxt_s;
            cm_ptr_r   <= cm_ptr_nxt_s;
            mode_r     <= mode_nxt_s;
            drop_cnt_r <= drop_cnt_nxt_s;
        end
    end

    line_fifo_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .ADDR_WIDTH (AW)
    ) u_mem (
        .clk     (clk),
        .wr_en   (wr_en_s),
        .wr_addr (wr_ptr_r[AW-1:0]),
        .wr_data (s_axis_tdata),
        .rd_addr (rd_ptr_r[AW-1:0]),
        .rd_data (m_axis_tdata)
    );

    assign s_axis_tready = s_ready_s;
    assign m_axis_tvalid = m_valid_s;
    assign mode_o        = mode_r[0];
    assign level_o       = wr_ptr_r - rd_ptr_r;
    assign drop_count_o  = drop_cnt_r;

endmodule : uart_line_buffer

// File: tb/tb_uart_line_buffer.sv
// -----------------------------------------------------------------------------
// tb_uart_line_buffer
// Scoreboard bench for uart_line_buffer (DATA_WIDTH=8, DEPTH=16, TERM=0x0D).
// A behavioural model of level, releasable bytes, mode and drops is stepped
// once per cycle; accepted bytes are queued and compared on every pop.
// -----------------------------------------------------------------------------
module tb_uart_line_buffer;

    localparam int DEPTH = 16;

    logic       clk;
    logic       rst;
    logic [7:0] s_axis_tdata;
    logic       s_axis_tvalid;
    logic       s_axis_tready;
    logic [7:0] m_axis_tdata;
    logic       m_axis_tvalid;
    logic       m_axis_tready;
    logic       line_mode_i;
    logic       mode_o;
    logic [4:0] level_o;
    logic [7:0] drop_count_o;

    int n_checks = 0;
    int n_errors = 0;

    // Model state
    logic [7:0] sb_q[$];
    int         mdl_lvl   = 0;
    int         mdl_avail = 0;
    int         mdl_drops = 0;
    logic       mdl_mode  = 1'b0;

    uart_line_buffer #(
        .DATA_WIDTH (8),
        .DEPTH      (DEPTH),
        .TERM       (8'h0D)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .line_mode_i   (line_mode_i),
        .mode_o        (mode_o),
        .level_o       (level_o),
        .drop_count_o  (drop_count_o)
    );

    // Free-running clock, 10 time units period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_value(input string tag, input logic [31:0] obs,
                               input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s got=0x%0h want=0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // One cycle: sample and score at negedge, advance model, then cross posedge.
    task automatic step();
        logic full;
        logic s_hs;
        logic m_hs;
        logic wr;
        int   lvl_n;
        @(negedge clk);
        full = (mdl_lvl == DEPTH);
        check_value("level",  32'(level_o),       32'(mdl_lvl));
        check_value("s_rdy",  32'(s_axis_tready), mdl_mode ? 32'd1 : 32'(!full));
        check_value("m_vld",  32'(m_axis_tvalid), 32'(mdl_avail > 0));
        check_value("mode",   32'(mode_o),        32'(mdl_mode));
        check_value("drops",  32'(drop_count_o),  32'(mdl_drops));
        s_hs = s_axis_tvalid && s_axis_tready;
        m_hs = m_axis_tvalid && m_axis_tready;
        if (m_hs) begin
            if (sb_q.size() == 0) begin
                check_value("sb_pop_empty", 32'(sb_q.size()), 32'd1);
            end else begin
                check_value("data", 32'(m_axis_tdata), 32'(sb_q.pop_front()));
            end
        end
        wr = s_hs && !full;
        if (wr) begin
            sb_q.push_back(s_axis_tdata);
        end
        lvl_n = mdl_lvl + (wr ? 1 : 0) - (m_hs ? 1 : 0);
        if (!mdl_mode) begin
            mdl_avail = lvl_n;
        end else if (wr && s_axis_tdata == 8'h0D) begin
            mdl_avail = lvl_n;
        end else if (full && mdl_avail == 0) begin
            mdl_avail = lvl_n;
        end else begin
            mdl_avail = mdl_avail - (m_hs ? 1 : 0);
        end
        if (s_hs && full && mdl_mode && mdl_drops < 255) begin
            mdl_drops++;
        end
        if (mdl_lvl == 0 && line_mode_i != mdl_mode) begin
            mdl_mode = line_mode_i;
        end
        mdl_lvl = lvl_n;
        @(posedge clk);
        #1;
    endtask

    task automatic push_byte(input logic [7:0] b);
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = b;
        step();
        s_axis_tvalid = 1'b0;
    endtask

    task automatic drain(input int max_cycles);
        m_axis_tready = 1'b1;
        for (int i = 0; i < max_cycles && mdl_lvl > 0; i++) begin
            step();
        end
        check_value("drain_level", 32'(mdl_lvl), 32'd0);
        check_value("sb_empty", 32'(sb_q.size()), 32'd0);
    endtask

    initial begin
        logic [7:0] hi_line [3];
        hi_line[0] = 8'h48;
        hi_line[1] = 8'h49;
        hi_line[2] = 8'h0D;

        rst           = 1'b0;
        s_axis_tdata  = 8'h00;
        s_axis_tvalid = 1'b0;
        m_axis_tready = 1'b0;
        line_mode_i   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        // Reset state
        check_value("rst_level", 32'(level_o),       32'd0);
        check_value("rst_vld",   32'(m_axis_tvalid), 32'd0);
        check_value("rst_rdy",   32'(s_axis_tready), 32'd1);
        check_value("rst_mode",  32'(mode_o),        32'd0);
        check_value("rst_drops", 32'(drop_count_o),  32'd0);
        rst = 1'b1;
        step();

        // ECHO pass-through
        m_axis_tready = 1'b1;
        push_byte(8'h41);
        push_byte(8'h42);
        push_byte(8'h43);
        repeat (3) step();
        check_value("echo_sb_empty", 32'(sb_q.size()), 32'd0);

        // ECHO back-pressure
        m_axis_tready = 1'b0;
        for (int i = 0; i < 20; i++) begin
            push_byte(8'h10 + 8'(i));
        end
        check_value("bp_level", 32'(level_o),       32'd16);
        check_value("bp_rdy",   32'(s_axis_tready), 32'd0);
        drain(40);
        check_value("bp_drops", 32'(drop_count_o), 32'd0);

        // Switch to LINE and release "HI\r"
        line_mode_i = 1'b1;
        repeat (2) step();
        check_value("line_mode", 32'(mode_o), 32'd1);
        m_axis_tready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            push_byte(hi_line[i]);
        end
        repeat (5) step();
        check_value("line_sb_empty", 32'(sb_q.size()), 32'd0);

        // LINE overflow: 18 bytes, no terminator, reader stalled
        m_axis_tready = 1'b0;
        for (int i = 0; i < 18; i++) begin
            push_byte(8'h60 + 8'(i));
        end
        check_value("ovf_drops", 32'(drop_count_o),  32'd2);
        check_value("ovf_vld",   32'(m_axis_tvalid), 32'd1);
        drain(40);

        // Mode switch while non-empty
        line_mode_i = 1'b0;
        repeat (2) step();
        check_value("back_echo", 32'(mode_o), 32'd0);
        m_axis_tready = 1'b0;
        push_byte(8'hA1);
        push_byte(8'hA2);
        push_byte(8'hA3);
        line_mode_i = 1'b1;
        repeat (4) step();
        check_value("sw_hold_mode", 32'(mode_o), 32'd0);
        m_axis_tready = 1'b1;
        repeat (3) step();
        check_value("sw_still_echo", 32'(mode_o), 32'd0);
        step();
        check_value("sw_now_line", 32'(mode_o), 32'd1);

        // Reset mid-line: 5 stored, 3 dropped in total
        m_axis_tready = 1'b0;
        push_byte(8'hB0);
        for (int i = 1; i < 17; i++) begin
            push_byte(8'hB0 + 8'(i));
        end
        m_axis_tready = 1'b1;
        repeat (11) step();
        m_axis_tready = 1'b0;
        step();
        check_value("pre_rst_level", 32'(level_o),      32'd5);
        check_value("pre_rst_drops", 32'(drop_count_o), 32'd3);
        line_mode_i = 1'b0;
        rst = 1'b0;
        #2;
        check_value("arst_level", 32'(level_o),       32'd0);
        check_value("arst_vld",   32'(m_axis_tvalid), 32'd0);
        check_value("arst_drops", 32'(drop_count_o),  32'd0);
        check_value("arst_mode",  32'(mode_o),        32'd0);
        rst = 1'b1;
        sb_q.delete();
        mdl_lvl   = 0;
        mdl_avail = 0;
        mdl_drops = 0;
        mdl_mode  = 1'b0;

        // Post-reset ECHO sanity
        m_axis_tready = 1'b1;
        push_byte(8'h55);
        repeat (2) step();
        check_value("post_rst_sb_empty", 32'(sb_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    // Absolute time limit so the run cannot hang.
    initial begin
        #200000;
        $display("FAIL timeout reached at %0t", $time);
        $fatal(1, "timeout");
    end

endmodule : tb_uart_line_buffer

// File: doc/uart_line_buffer.md
# uart_line_buffer

Parametrised AXI-stream buffer between `uart_rx` and `uart_tx` in the UART top level, replacing the direct rx→tx wire-up. It has two modes:
- **ECHO:** a plain FIFO that absorbs back-pressure.
- **LINE:** bytes are held until a terminator byte arrives, then the whole line is released to the transmitter.

It also exposes fill level and a dropped-byte counter for debug and LEDs.

## Interface

Parameters:
- `DATA_WIDTH`, 8: byte width on both streams.
- `DEPTH`, 16: FIFO entries. Must be a power of two, ≥ 2.
- `TERM`, 8'h0D: line terminator in LINE mode. Only the low `DATA_WIDTH` bits are compared.

Ports:
- `clk` in, 1: single clock. All logic is on its rising edge.
- `rst` in, 1: asynchronous reset, active-low. Asserted when 0, released synchronously by the board reset logic.
- `s_axis_tdata` in, `DATA_WIDTH`: byte from `uart_rx`.
- `s_axis_tvalid` in, 1: input byte valid.
- `s_axis_tready` out, 1: block accepts the input byte.
- `m_axis_tdata` out, `DATA_WIDTH`: byte to `uart_tx`.
- `m_axis_tvalid` out, 1: output byte valid.
- `m_axis_tready` in, 1: `uart_tx` accepts the output byte.
- `line_mode_i` in, 1: requested mode. 0 = ECHO, 1 = LINE.
- `mode_o` out, 1: mode currently in effect.
- `level_o` out, `$clog2(DEPTH)+1`: entries stored.
- `drop_count_o` out, 8: bytes dropped in LINE mode. Saturates at 255.

## Operation

- **Storage.** Register array of `DEPTH` entries with `wr_ptr`, `rd_ptr` and `cm_ptr` (commit pointer), each `$clog2(DEPTH)+1` bits wide.
  - empty = `wr_ptr == rd_ptr`.
  - full = MSBs differ and the lower bits are equal.
  - Pointers wrap naturally modulo 2·`DEPTH`.
- **Mode state machine.** States ECHO and LINE; reset state is ECHO.
  - The mode changes only when empty and `line_mode_i` differs from the current mode.
  - Otherwise a request is held pending. It is not latched: the input is re-evaluated every cycle.
  - `mode_o` shows the current state.
- **ECHO.**
  - `s_axis_tready` = !full.
  - Push on `s_axis_tvalid && s_axis_tready`.
  - `cm_ptr` tracks `wr_ptr`.
  - Nothing is dropped.
- **LINE.**
  - `s_axis_tready` = 1 always.
  - A byte handshaken while full at the start of the cycle is discarded and `drop_count_o` increments, even if a pop occurs in the same cycle.
  - Writing `TERM` sets `cm_ptr` to `wr_ptr`+1 (the post-write pointer).
  - **Anti-deadlock:** if full and `cm_ptr == rd_ptr`, set `cm_ptr` to `wr_ptr` on the next cycle. The partial line is released.
- **Output (both modes).**
  - `m_axis_tvalid` = (`rd_ptr != cm_ptr`).
  - `m_axis_tdata` = mem[`rd_ptr`].
  - Pop on `m_axis_tvalid && m_axis_tready`.
  - `m_axis_tdata` stays stable while valid and not ready.
- **Level.** `level_o` = `wr_ptr - rd_ptr`, updated every cycle.
- **Simultaneous push and pop.** Both take effect, and the level is unchanged. In ECHO mode a push while full is impossible because tready is low.

## Timing

- **Reset values.** All pointers 0, state ECHO, `drop_count_o` 0, `m_axis_tvalid` 0, `level_o` 0, `s_axis_tready` 1. Array contents are don't-care.
- **Reset mid-operation.** Buffered bytes are discarded and the counter is cleared, with no partial outputs.
- **ECHO latency.** A byte accepted at edge N gives `m_axis_tvalid` = 1 after edge N; first output is available in cycle N+1.
- **LINE latency.** Bytes become valid the cycle after the `TERM` byte is accepted. A forced release is valid two cycles after full is reached.
- **Handshake outputs.**
  - `s_axis_tready` is combinational from registered full and state only. It never depends on `m_axis_tready`.
  - `m_axis_tvalid` is combinational from registered pointers only.
- **Throughput.** One byte per cycle in, one byte per cycle out.

## Structure

- **Package `uart_pkg`.**
  - Typedef `buf_mode_e`: `MODE_ECHO`, `MODE_LINE`.
  - Constant `UART_TERM_CR` = 8'h0D, used as the `TERM` default.
  - Constant `UART_PRESCALE` = 16'd35, shared by the top level.
- **Sub-module `line_fifo_mem`.**
  - Parametrised storage array: write port plus asynchronous read port.
  - No reset on the contents.
- **`uart_line_buffer` itself** holds the pointers, mode FSM and counter.
- **Top-level change.** `uart_rx.m_axis_*` connects to `s_axis_*`, and `m_axis_*` connects to `uart_tx.s_axis_*`.

## Test plan

- **ECHO pass-through.** Push 0x41, 0x42, 0x43 with `m_axis_tready`=1.
  - Expect the same three bytes out, in order, each one cycle after its acceptance.
  - Expect `level_o` ≤ 1.
- **ECHO back-pressure, `DEPTH`=16.** Hold `m_axis_tready`=0 and push 20 bytes.
  - Expect `s_axis_tready` to drop after 16 bytes with `level_o`=16.
  - After releasing ready, expect all 16 bytes out unchanged and `drop_count_o`=0.
- **LINE release.** Send "HI", then 0x0D.
  - Expect `m_axis_tvalid`=0 until the cycle after 0x0D is accepted.
  - Then expect 0x48, 0x49, 0x0D out back-to-back.
- **LINE overflow, `DEPTH`=16, ready=0.** Send 18 bytes with no terminator.
  - Expect `drop_count_o`=2.
  - Expect forced release: `m_axis_tvalid`=1 two cycles after full.
  - Expect the first 16 bytes out after releasing ready.
- **Mode switch while non-empty.** Store 3 bytes in ECHO, set `line_mode_i`=1.
  - Expect `mode_o` to stay 0 until all 3 bytes are popped, then become 1 on the next cycle.
- **Asynchronous reset mid-line.** In LINE mode with 5 bytes stored and drops=3, pulse `rst`=0 mid-cycle.
  - Expect immediately: `level_o`=0, `m_axis_tvalid`=0, `drop_count_o`=0, `mode_o`=0.
